// File: rtl/sa_ram_rws_256x128_arb.sv
// sa_ram_rws_256x128_arb
//   Shares one sa_ram_rws_256x128 RAM (1 read port, 1 write port, 1-cycle
//   read latency) between NUM_RD read clients and NUM_WR write clients.
//   The read and write ports each have an independent round-robin arbiter.
//   Grants are combinational, and each read response is routed back to the
//   client that was granted.
//
// Optional build macro: SA_RAM_ARB_INIT_EN
//   When defined, an INIT sweep writes zero to all 256 RAM words after reset,
//   before any requests are accepted.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   rd_req_vld/rdy/addr       read request handshake (addr client i at [i*AW +: AW])
//   rd_rsp_vld, rd_rsp_data   one-cycle response pulse per client, shared data bus
//   wr_req_vld/rdy/addr/data  write request handshake
//   ram_ra/re/wa/we/di        RAM pins driven by this block
//   ram_dout                  RAM read data
//   init_done                 high while requests are being accepted
module sa_ram_rws_256x128_arb #(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD-1:0]    rd_req_vld,
  output logic [NUM_RD-1:0]    rd_req_rdy,
  input  logic [NUM_RD*AW-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]    rd_rsp_vld,
  output logic [DW-1:0]        rd_rsp_data,
  input  logic [NUM_WR-1:0]    wr_req_vld,
  output logic [NUM_WR-1:0]    wr_req_rdy,
  input  logic [NUM_WR*AW-1:0] wr_req_addr,
  input  logic [NUM_WR*DW-1:0] wr_req_data,
  output logic [AW-1:0]        ram_ra,
  output logic                 ram_re,
  output logic [AW-1:0]        ram_wa,
  output logic                 ram_we,
  output logic [DW-1:0]        ram_di,
  input  logic [DW-1:0]        ram_dout,
  output logic                 init_done
);

  localparam int unsigned RPW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int unsigned WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN} state_t;

  state_t         state_q, state_d;
  logic           run;
  logic [RPW-1:0] rd_ptr_q, rd_gnt_id, rd_idx;
  logic [WPW-1:0] wr_ptr_q, wr_gnt_id, wr_idx;
  logic           rd_gnt_any, wr_gnt_any;
  logic           tag_vld_q;
  logic [RPW-1:0] tag_id_q;

`ifdef SA_RAM_ARB_INIT_EN
  logic [AW-1:0]  init_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                   init_cnt_q <= '0;
    else if (state_q == S_INIT) init_cnt_q <= init_cnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef SA_RAM_ARB_INIT_EN
      S_RESET: state_d = S_INIT;
      S_INIT:  if (init_cnt_q == '1) state_d = S_RUN;
`else
      S_RESET: state_d = S_RUN;
      S_INIT:  state_d = S_RUN;
`endif
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RESET;
    endcase
  end

  // Reset gates every output combinationally, so outputs are zero even in
  // the first reset cycle while the state register still holds RUN.
  assign run       = (state_q == S_RUN) && !rst;
  assign init_done = run;

  // Round-robin search: take the first valid client starting at the pointer.
  always_comb begin
    rd_gnt_any = 1'b0;
    rd_gnt_id  = '0;
    rd_idx     = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_idx = RPW'((32'(rd_ptr_q) + i) % NUM_RD);
      if (!rd_gnt_any && run && rd_req_vld[rd_idx]) begin
        rd_gnt_any = 1'b1;
        rd_gnt_id  = rd_idx;
      end
    end
  end

  always_comb begin
    wr_gnt_any = 1'b0;
    wr_gnt_id  = '0;
    wr_idx     = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      wr_idx = WPW'((32'(wr_ptr_q) + i) % NUM_WR);
      if (!wr_gnt_any && run && wr_req_vld[wr_idx]) begin
        wr_gnt_any = 1'b1;
        wr_gnt_id  = wr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      tag_vld_q <= 1'b0;
      tag_id_q  <= '0;
    end else begin
      if (rd_gnt_any) rd_ptr_q <= RPW'((32'(rd_gnt_id) + 1) % NUM_RD);
      if (wr_gnt_any) wr_ptr_q <= WPW'((32'(wr_gnt_id) + 1) % NUM_WR);
      tag_vld_q <= rd_gnt_any;
      tag_id_q  <= rd_gnt_id;
    end
  end

  always_comb begin
    rd_req_rdy = '0;
    ram_re     = rd_gnt_any;
    ram_ra     = '0;
    if (rd_gnt_any) begin
      rd_req_rdy[rd_gnt_id] = 1'b1;
      ram_ra                = rd_req_addr[rd_gnt_id*AW +: AW];
    end
  end

  always_comb begin
    wr_req_rdy = '0;
    ram_we     = 1'b0;
    ram_wa     = '0;
    ram_di     = '0;
    if (wr_gnt_any) begin
      wr_req_rdy[wr_gnt_id] = 1'b1;
      ram_we                = 1'b1;
      ram_wa                = wr_req_addr[wr_gnt_id*AW +: AW];
      ram_di                = wr_req_data[wr_gnt_id*DW +: DW];
    end
`ifdef SA_RAM_ARB_INIT_EN
    if (state_q == S_INIT && !rst) begin
      ram_we = 1'b1;
      ram_wa = init_cnt_q;
      ram_di = '0;
    end
`endif
  end

  // Response tag from the previous cycle's grant.
  always_comb begin
    rd_rsp_vld = '0;
    if (tag_vld_q && !rst) rd_rsp_vld[tag_id_q] = 1'b1;
  end

  assign rd_rsp_data = ram_dout;

endmodule

// File: doc/sa_ram_rws_256x128_arb.md
Name: sa_ram_rws_256x128_arb

Overview:
Arbiter/sequencer that shares one sa_ram_rws_256x128 two-port RAM (1 read port, 1 write port, 1-cycle read latency) between NUM_RD read clients and NUM_WR write clients.
Independent round-robin arbitration on the read and write ports, valid/ready request handshake, and response routing back to the granted read client.
Sits beside the RAM instance (does not instantiate it) and drives the RAM's ra/re/wa/we/di pins; it receives dout.

Parameters:
NUM_RD, 2, number of read clients (1..4)
NUM_WR, 2, number of write clients (1..4)
AW, 8, address width; fixed at 8 for the 256-deep RAM
DW, 128, data width; fixed at 128

Ports:
clk  in  1  core clock, shared with RAM
rst  in  1  synchronous reset, active-high
rd_req_vld  in  NUM_RD  per-client read request valid
rd_req_rdy  out  NUM_RD  per-client read grant (one-hot or zero)
rd_req_addr  in  NUM_RD*AW  per-client read address, client i at [i*AW +: AW]
rd_rsp_vld  out  NUM_RD  per-client read data valid pulse
rd_rsp_data  out  DW  read data, shared bus, qualified by rd_rsp_vld
wr_req_vld  in  NUM_WR  per-client write request valid
wr_req_rdy  out  NUM_WR  per-client write grant (one-hot or zero)
wr_req_addr  in  NUM_WR*AW  per-client write address
wr_req_data  in  NUM_WR*DW  per-client write data
ram_ra  out  AW  RAM read address
ram_re  out  1  RAM read enable
ram_wa  out  AW  RAM write address
ram_we  out  1  RAM write enable
ram_di  out  DW  RAM write data
ram_dout  in  DW  RAM read data
init_done  out  1  high once the controller accepts requests

Behaviour:
- Reset: single clock, clk; rst is synchronous and active-high. While rst is high and in the first cycle after it, all outputs are 0: rdy, rsp_vld, ram_re, ram_we, ram_ra, ram_wa, ram_di, init_done. Both round-robin pointers reset to client 0. Any in-flight read response is dropped; no rd_rsp_vld follows a reset.
- State machine: RESET -> (INIT if SA_RAM_ARB_INIT_EN) -> RUN. Without the macro, RESET -> RUN one cycle after rst deasserts. init_done = (state == RUN).
- Arbitration is combinational from the req_vld inputs and registered pointers; grant is valid in the same cycle.
- Grant rule: search starts at the pointer and takes the first asserted vld; rdy is high only for that client, and only in RUN.
- Pointer update: after a grant to client k, the pointer becomes (k+1) mod NUM. It does not move when nothing is granted.
- Read transfer (cycle T): grant implies ram_re=1 and ram_ra=granted addr, both combinational.
- Read response: a registered tag stores {vld, client id}. At cycle T+1, rd_rsp_vld[id]=1 for exactly one cycle and rd_rsp_data=ram_dout. Throughput is one read per cycle; back-to-back grants give back-to-back responses.
- Response bus outside rsp_vld: rd_rsp_data is unspecified. It is never qualified without rsp_vld.
- Write transfer (cycle T): grant implies ram_we=1 and ram_wa/ram_di=granted client's addr/data, written at the T edge. Writes take effect immediately; there is no response.
- Read/write same cycle, same address: write-first. The response at T+1 carries the new data, because the RAM latches ra and writes on the same edge and reads the array after.
- Fairness: read and write ports are independent; neither blocks the other. A client holding vld waits at most NUM-1 grants.
- Input stability: a client must hold vld/addr/data stable until rdy. Dropping vld without rdy is legal (request withdrawn).
- Address range: addresses wrap naturally (8-bit, 0..255); no range checking.
- Idle outputs: ram_re=0 and ram_we=0 whenever no grant. ram_ra/ram_wa/ram_di hold their last value or 0; they are don't-care.

Optional Feature:
Macro SA_RAM_ARB_INIT_EN. When defined, the INIT state sweeps an 8-bit counter 0..255, driving ram_we=1, ram_wa=counter, ram_di=0 each cycle. This takes 256 cycles; RUN is entered the cycle after address 255 is written. All rdy stay 0 and init_done=0 during INIT. rst during INIT restarts the sweep from address 0. Without the macro, RAM contents after reset are undefined and RUN follows reset after one cycle.

Test Plan:
- Reset then idle (macro off): rst high 3 cycles, release. Required: init_done=1 on the 2nd cycle after release; all rdy/rsp_vld/ram_re/ram_we stay 0.
- Single client write/read: wr client0 addr 0x10 data 0xA5..A5 granted in cycle T. Then rd client1 addr 0x10 in cycle T+2. Required: rd_rsp_vld=2'b10 at T+3 with data 0xA5..A5.
- Round-robin under contention: both read clients hold vld for 6 cycles. Required: rdy sequence 01,10,01,10,01,10, and rsp_vld follows the same pattern one cycle later.
- Same-address collision: write 0x3C data X and read 0x3C in the same cycle. Required: the response the next cycle equals X.
- Reset mid-read: grant a read in cycle T, assert rst at T+1. Required: rd_rsp_vld stays 0 and the pointers return to 0.
- Init sweep (macro on): after reset, require ram_we=1 for 256 consecutive cycles with ram_wa 0..255 and ram_di=0, and rdy=0 throughout. init_done rises the next cycle; reading 0xFF then returns 0.
